// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
//   state_e       : loader FSM states
//   NUM_LANES     : bytes per instruction word
//   LANE_W        : bits per byte lane
//   END_WORD_DEF  : default end-of-program marker
package loader_pkg;
  localparam int          NUM_LANES    = 4;
  localparam int          LANE_W       = 8;
  localparam logic [31:0] END_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_e;
endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   clr         : synchronous clear of partial word and byte index (break)
//   en          : bytes are accepted only while high
//   rx_valid    : byte strobe, rx_data valid this cycle
//   rx_data     : received byte
//   byte_idx    : lane the next accepted byte lands in
//   word_stb    : combinational, high when the final lane is accepted this cycle
//   word        : assembled word; top lane comes straight from rx_data so the
//                 word is complete in the same cycle as word_stb
module word_assembler
  import loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         rx_valid,
  input  logic [LANE_W-1:0]            rx_data,
  output logic [$clog2(NUM_LANES)-1:0] byte_idx,
  output logic                         word_stb,
  output logic [NUM_LANES*LANE_W-1:0]  word
);
  localparam int IDX_W = $clog2(NUM_LANES);

  // Only the lower lanes need storage; the top lane is consumed on arrival.
  logic [NUM_LANES-2:0][LANE_W-1:0] lanes;
  logic                             accept;

  assign accept   = en & rx_valid & ~clr;
  assign word_stb = accept && (byte_idx == IDX_W'(NUM_LANES-1));
  assign word     = {rx_data, lanes};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (clr) begin
      byte_idx <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_LANES-1; i++)
        if (byte_idx == IDX_W'(i)) lanes[i] <= rx_data;
      byte_idx <= byte_idx + 1'b1;  // wraps to 0 after the top lane
    end
  end
endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: UART bytes -> 32-bit little-endian words -> consecutive imem
// words. Holds the core in reset until the end-of-program marker arrives.
// Optional feature macro: LOADER_TIMEOUT_EN (idle timeout on partial words).
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   rx_valid/rx_data       : received byte strobe and data
//   rx_break               : UART BREAK pulse, restarts the load from address 0
//   imem_we/addr/wdata     : instruction memory write port (one cycle per word)
//   cpu_rstn               : core reset, released when the load completes
//   write_done             : sticky load-complete flag
//   load_error             : sticky overflow / timeout flag
//   words_loaded           : number of words committed
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter logic [31:0] END_WORD       = END_WORD_DEF,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              write_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);
  state_e      state_q, state_d;
  logic        loading;
  logic        brk;
  logic [1:0]  byte_idx;
  logic        word_stb;
  logic [31:0] word;
  logic        timeout_hit;

  assign loading = (state_q == LOAD) || (state_q == COMMIT);
  assign brk     = loading & rx_break;

  word_assembler u_asm (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (brk),
    .en       (loading),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .byte_idx (byte_idx),
    .word_stb (word_stb),
    .word     (word)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_q;
  logic            idle_clr;

  // Only a partially received word is subject to the idle limit.
  assign idle_clr    = (state_q != LOAD) || (byte_idx == 2'd0) || rx_valid || rx_break;
  assign timeout_hit = !idle_clr && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn || idle_clr) idle_q <= '0;
    else                     idle_q <= idle_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0) ^ (|byte_idx);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (rx_break)         state_d = LOAD;
        else if (word_stb)    state_d = (word == END_WORD) ? DONE : COMMIT;
        else if (timeout_hit) state_d = ERROR;
      end
      COMMIT: begin
        // The write itself completes regardless of a break this cycle.
        if (rx_break)                       state_d = LOAD;
        else if (imem_addr == {ADDR_W{1'b1}}) state_d = ERROR;
        else                                state_d = LOAD;
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= LOAD;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      write_done   <= 1'b0;
      cpu_rstn     <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_we    <= (state_d == COMMIT);
      write_done <= (state_d == DONE);
      cpu_rstn   <= (state_d == DONE);
      load_error <= (state_d == ERROR);
      if (state_d == COMMIT) imem_wdata <= word;
      if (brk) begin
        imem_addr    <= '0;
        words_loaded <= '0;
      end else if (state_q == COMMIT) begin
        words_loaded <= words_loaded + 1'b1;
        // No wrap: the address stays on the last word when overflowing.
        if (state_d != ERROR) imem_addr <= imem_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;
  localparam int          AW    = 4;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] ENDW  = 32'hFFFF_FFFF;

  logic          clk = 1'b0, resetn = 1'b0;
  logic          rx_valid = 1'b0, rx_break = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          imem_we, cpu_rstn, write_done, load_error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  uart_imem_loader #(.ADDR_W(AW), .END_WORD(ENDW), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rstn(cpu_rstn), .write_done(write_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] img [DEPTH];
  int          n_cmp = 0, n_bad = 0;

  // Reference model: a loader that counts words and stops on marker/overflow.
  logic [7:0] m_part[$];
  int         m_addr = 0;
  bit         m_done = 0, m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (resetn && imem_we) begin
      img[imem_addr] <= imem_wdata;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic gap(); repeat ($urandom_range(0, 2)) cyc(); endtask

  task automatic model_byte(input logic [7:0] b, input bit brk);
    logic [31:0] w;
    wr_t e;
    if (m_done || m_err) return;
    if (brk) begin m_part.delete(); m_addr = 0; return; end
    m_part.push_back(b);
    if (m_part.size() == 4) begin
      w = {m_part[3], m_part[2], m_part[1], m_part[0]};
      m_part.delete();
      if (w == ENDW) m_done = 1;
      else begin
        e.addr = m_addr; e.data = w;
        exp_q.push_back(e);
        m_addr++;
        if (m_addr == DEPTH) m_err = 1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit brk = 0);
    rx_valid = 1'b1; rx_data = b; rx_break = brk;
    cyc();
    rx_valid = 1'b0; rx_break = 1'b0;
    model_byte(b, brk);
  endtask

  task automatic pulse_break();
    rx_break = 1'b1; cyc(); rx_break = 1'b0;
    model_byte(8'h00, 1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin send_byte(w[8*i +: 8]); gap(); end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
    if (w == ENDW) w = 32'h0000_0013;
    return w;
  endfunction

  task automatic do_reset();
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    resetn = 1'b0; rx_valid = 1'b0; rx_break = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    m_part.delete(); m_addr = 0; m_done = 0; m_err = 0;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_we"},    32'(imem_we), 32'd0);
    check({tag, "_addr"},  32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_flags"}, {29'd0, cpu_rstn, write_done, load_error}, 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    repeat (3) cyc();
    @(negedge clk);
    check({tag, "_words"},      32'(words_loaded), 32'(m_addr));
    check({tag, "_write_done"}, 32'(write_done), 32'(m_done));
    check({tag, "_cpu_rstn"},   32'(cpu_rstn), 32'(m_done));
    check({tag, "_load_error"}, 32'(load_error), 32'(m_err));
  endtask

  initial begin
    logic [7:0]  prog [11];
    logic [31:0] w;
    prog = '{8'h13, 8'h01, 8'h01, 8'hfb, 8'h23, 8'h26, 8'h81, 8'h04, 8'hff, 8'hff, 8'hff};

    do_reset();
    check_zero("reset");

    // Fixed program followed by the marker.
    foreach (prog[i]) begin send_byte(prog[i]); gap(); end
    send_byte(8'hff);
    @(negedge clk);
    check("done_at_n1", 32'(write_done), 32'd1);
    check("rstn_at_n1", 32'(cpu_rstn), 32'd1);
    check_quiet("prog");
    check("img0", img[0], 32'hfb010113);
    check("img1", img[1], 32'h04812623);

    // Trailing bytes after DONE are ignored.
    send_word(ENDW);
    send_word(32'h0);
    pulse_break();
    check_quiet("trail");

    // Break mid-word restarts the load.
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    pulse_break();
    send_word(32'h0680006f);
    check_quiet("brk");
    check("brk_img0", img[0], 32'h0680006f);
    send_byte(8'haa, 1);                 // break wins, byte dropped
    for (int i = 0; i < 6; i++) send_word(rand_word());
    w = rand_word();
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    pulse_break();                       // lands on the COMMIT cycle
    for (int i = 0; i < 5; i++) send_word(rand_word());
    send_word(ENDW);
    check_quiet("rand");

    // Reset in the middle of the second word.
    do_reset();
    send_word(rand_word());
    send_byte(8'h5a); send_byte(8'ha5);
    cyc();
    do_reset();
    check_zero("midrst");
    w = rand_word();
    send_word(w);
    check_quiet("midrst_reload");
    check("midrst_img0", img[0], w);

    // Overflow: fill every address, then one more cycle into ERROR.
    do_reset();
    for (int i = 0; i < DEPTH-1; i++) send_word(rand_word());
    w = rand_word();
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    @(negedge clk);
    check("ovf_err_n1", 32'(load_error), 32'd0);
    @(negedge clk);
    check("ovf_err_n2", 32'(load_error), 32'd1);
    check("ovf_rstn",   32'(cpu_rstn), 32'd0);
    send_word(rand_word());
    check_quiet("ovf");

`ifdef LOADER_TIMEOUT_EN
    do_reset();
    send_byte(8'h01); send_byte(8'h02);
    repeat (99) cyc();
    @(negedge clk);
    check("to_before", 32'(load_error), 32'd0);
    cyc();
    @(negedge clk);
    check("to_hit", 32'(load_error), 32'd1);
    m_err = 1; m_part.delete();
    check_quiet("to");
    do_reset();
    repeat (10_000) cyc();
    check_quiet("to_idle0");
`endif

    repeat (3) cyc();
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
